ltcminer_icarus_io: RTL and testbench

// - Icarus-protocol serial front end of the scrypt miner: UART-receives an 84-byte getwork frame, loads

---
 rtl/ltcminer_icarus_io.sv | 383 ++++++++++++++++++++++++++++++++++++++
 tb/tb_ltcminer_icarus_io.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltcminer_icarus_io.sv
// ---------------------------------------------------------------------------
// ltcminer_icarus_io
//
// Icarus-protocol serial front end for the scrypt miner. A built-in 8N1 UART
// receiver assembles 84-byte getwork frames from the host. Each frame carries:
//   bytes 0..3   control word (the low 16 bits are the target high word)
//   bytes 4..7   start nonce
//   bytes 8..83  76-byte block header
// The block hands the header and a running nonce to an external hash core.
// Golden nonces come back from the core. They are queued in a 4-entry FIFO and
// returned to the host through a built-in 8N1 UART transmitter. Each nonce is
// sent as 4 bytes, least-significant byte first.
//
// Parameters
//   comm_clk_frequency : clk frequency in Hz
//   baud_rate          : serial bit rate; one bit lasts
//                        DIV = comm_clk_frequency / baud_rate clocks
//
// Ports
//   clk, rst_n   : system clock (posedge) and asynchronous active-low reset
//   RxD / TxD    : host serial in / out, both idle high
//   work_data    : 608-bit header; frame byte 8 sits at [607:600]
//   work_nonce   : nonce the core should hash next
//   work_load    : 1-cycle pulse; a new frame was latched and the core must
//                  restart
//   core_next    : 1-cycle pulse from the core; it took work_nonce, so advance
//   hash_valid   : 1-cycle pulse from the core; hash_hi/hash_nonce are valid
//   hash_hi      : most-significant hash word for hash_nonce
//   hash_nonce   : nonce that produced hash_hi
//   led          : {tx_busy, golden_seen, frame_loaded, rx_active}
//
// Handshake: all core-side signals are single-cycle strobes with no
// back-pressure. A strobe is acted on in the cycle it is high. A golden nonce
// that arrives while the FIFO is full is dropped.
//
// Optional feature (macro LTCMINER_DYNPLL_EN): if a frame's control word
// starts with 16'h55AA, its byte 3 is also driven on pll_mult. In that case
// pll_update pulses together with work_load.
// ---------------------------------------------------------------------------
module ltcminer_icarus_io #(
   parameter int comm_clk_frequency = 100_000_000,
   parameter int baud_rate          = 115_200
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         RxD,
   output logic         TxD,
   output logic [607:0] work_data,
   output logic [31:0]  work_nonce,
   output logic         work_load,
   input  logic         core_next,
   input  logic         hash_valid,
   input  logic [31:0]  hash_hi,
   input  logic [31:0]  hash_nonce,
   output logic [3:0]   led
`ifdef LTCMINER_DYNPLL_EN
   ,
   output logic [7:0]   pll_mult,
   output logic         pll_update
`endif
);

   localparam int DIV     = comm_clk_frequency / baud_rate;
   localparam int HALF    = DIV / 2;
   localparam int TIMEOUT = 20 * DIV;
   localparam int CW      = $clog2(TIMEOUT + 2);

   localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] TO_LIM  = CW'(TIMEOUT);
   localparam logic [CW-1:0] ONE     = CW'(1);

   // rx_buf holds the first 83 bytes of a frame; the 84th byte is still in
   // rx_shift when the frame is latched. Frame bit f is rx_buf[f-8]. Without
   // the PLL feature the two oldest control bytes are never used, so they
   // are allowed to fall off the top of the buffer.
`ifdef LTCMINER_DYNPLL_EN
   localparam int BUF_HI = 663;
`else
   localparam int BUF_HI = 647;
`endif

   // ------------------------------------------------------------------
   // RxD synchroniser and edge history
   // ------------------------------------------------------------------
   logic rx_meta, rx_s, rx_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= RxD;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // ------------------------------------------------------------------
   // UART receive FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     rx_state, rx_state_d;
   logic [CW-1:0] rx_cnt, rx_cnt_d;
   logic [2:0]    rx_bit, rx_bit_d;
   logic [7:0]    rx_shift, rx_shift_d;
   logic          rx_byte_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_state <= rx_state_d;
         rx_cnt   <= rx_cnt_d;
         rx_bit   <= rx_bit_d;
         rx_shift <= rx_shift_d;
      end
   end

   always_comb begin
      rx_state_d    = rx_state;
      rx_cnt_d      = rx_cnt;
      rx_bit_d      = rx_bit;
      rx_shift_d    = rx_shift;
      rx_byte_valid = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_s) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            // Re-check the line half a bit into the start bit. This rejects
            // glitches, and it puts every later sample near the middle of
            // its bit.
            if (rx_cnt == HALF_M1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt + ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt == DIV_M1) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s, rx_shift[7:1]};
               if (rx_bit == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt + ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt == DIV_M1) begin
               rx_cnt_d      = '0;
               rx_byte_valid = rx_s;   // a low stop bit means a framing error; drop the byte
               rx_state_d    = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt + ONE;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Frame assembly, inter-byte timeout and work latching
   // ------------------------------------------------------------------
   logic [BUF_HI:0] rx_buf;
   logic [6:0]      byte_cnt;
   logic [CW-1:0]   idle_cnt;
   logic            frame_done;
   logic [15:0]     target;
   logic            frame_loaded;

   assign frame_done = rx_byte_valid && (byte_cnt == 7'd83);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_buf   <= '0;
         byte_cnt <= '0;
         idle_cnt <= '0;
      end else if (rx_byte_valid) begin
         rx_buf   <= {rx_buf[BUF_HI-8:0], rx_shift};
         byte_cnt <= frame_done ? 7'd0 : byte_cnt + 7'd1;
         idle_cnt <= '0;
      end else if (byte_cnt != 7'd0) begin
         // A host that stalls mid-frame loses the partial frame. The next
         // byte it sends is then taken as byte 0 of a new frame.
         if (idle_cnt == TO_LIM) begin
            byte_cnt <= '0;
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + ONE;
         end
      end else begin
         idle_cnt <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_data    <= '0;
         work_nonce   <= '0;
         target       <= '0;
         work_load    <= 1'b0;
         frame_loaded <= 1'b0;
      end else begin
         work_load <= frame_done;
         if (frame_done) begin
            work_data    <= {rx_buf[599:0], rx_shift};
            work_nonce   <= rx_buf[631:600];
            target       <= rx_buf[647:632];
            frame_loaded <= 1'b1;
         end else if (core_next) begin
            work_nonce <= work_nonce + 32'd1;
         end
      end
   end

`ifdef LTCMINER_DYNPLL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pll_mult   <= '0;
         pll_update <= 1'b0;
      end else begin
         pll_update <= frame_done && (rx_buf[663:648] == 16'h55AA);
         if (frame_done && (rx_buf[663:648] == 16'h55AA)) begin
            pll_mult <= rx_buf[639:632];
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Golden check and result FIFO
   // ------------------------------------------------------------------
   // The compare uses the registered target. A result that arrives in the
   // same cycle a new frame latches is therefore judged against the old
   // target, which belongs to the work that produced it.
   logic        golden_match, fifo_push, fifo_pop, golden_seen;
   logic [31:0] fifo_mem [4];
   logic [1:0]  fifo_wr, fifo_rd;
   logic [2:0]  fifo_count;

   assign golden_match = hash_valid && (hash_hi <= {16'h0000, target});
   assign fifo_push    = golden_match && (fifo_count != 3'd4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
         fifo_count  <= '0;
         golden_seen <= 1'b0;
      end else begin
         if (golden_match) golden_seen <= 1'b1;
         if (fifo_push) begin
            fifo_mem[fifo_wr] <= hash_nonce;
            fifo_wr           <= fifo_wr + 2'd1;
         end
         if (fifo_pop) fifo_rd <= fifo_rd + 2'd1;
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 3'd1;
            2'b01:   fifo_count <= fifo_count - 3'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // UART transmit FSM: one 32-bit nonce as four back-to-back 8N1 bytes.
   // Sending the bytes LSB first with LSB-first bits makes the whole word
   // leave LSB first, so one right-shifting register serves all 32 bits.
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t     tx_state, tx_state_d;
   logic [CW-1:0] tx_cnt, tx_cnt_d;
   logic [2:0]    tx_bit, tx_bit_d;
   logic [1:0]    tx_byte, tx_byte_d;
   logic [31:0]   tx_word, tx_word_d;
   logic          txd_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_byte  <= '0;
         tx_word  <= '0;
         TxD      <= 1'b1;
      end else begin
         tx_state <= tx_state_d;
         tx_cnt   <= tx_cnt_d;
         tx_bit   <= tx_bit_d;
         tx_byte  <= tx_byte_d;
         tx_word  <= tx_word_d;
         TxD      <= txd_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state;
      tx_cnt_d   = tx_cnt;
      tx_bit_d   = tx_bit;
      tx_byte_d  = tx_byte;
      tx_word_d  = tx_word;
      fifo_pop   = 1'b0;
      case (tx_state)
         TX_IDLE: begin
            if (fifo_count != 3'd0) begin
               fifo_pop   = 1'b1;
               tx_word_d  = fifo_mem[fifo_rd];
               tx_byte_d  = '0;
               tx_cnt_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt == DIV_M1) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt + ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt == DIV_M1) begin
               tx_cnt_d  = '0;
               tx_word_d = {1'b0, tx_word[31:1]};
               if (tx_bit == 3'd7) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d = tx_bit + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt + ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt == DIV_M1) begin
               tx_cnt_d = '0;
               if (tx_byte == 2'd3) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_byte_d  = tx_byte + 2'd1;
                  tx_state_d = TX_START;
               end
            end else begin
               tx_cnt_d = tx_cnt + ONE;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase

      // TxD is registered. It is decoded from the state being entered, so
      // the serial line changes on the same edge as the state.
      case (tx_state_d)
         TX_START: txd_d = 1'b0;
         TX_DATA:  txd_d = tx_word_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Status LEDs
   // ------------------------------------------------------------------
   assign led = {(tx_state != TX_IDLE), golden_seen, frame_loaded,
                 ((rx_state != RX_IDLE) || (byte_cnt != 7'd0))};

endmodule

// File: tb/tb_ltcminer_icarus_io.sv
// ---------------------------------------------------------------------------
// tb_ltcminer_icarus_io
//
// Directed bench for ltcminer_icarus_io, run at 1 MHz / 115200 baud
// (8 clocks per bit). The stimulus is one linear sequence:
//   reset, frame load, nonce stepping, golden return, target boundary,
//   FIFO overflow, nonce wrap, partial-frame timeout, bad stop bit, and
//   reset during transmit.
// A serial monitor decodes TxD into a queue of 32-bit words. A counter
// counts the cycles in which work_load is high.
// ---------------------------------------------------------------------------
module tb_ltcminer_icarus_io;

   localparam int DIV = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         RxD = 1'b1;
   logic         TxD;
   logic [607:0] work_data;
   logic [31:0]  work_nonce;
   logic         work_load;
   logic         core_next = 1'b0;
   logic         hash_valid = 1'b0;
   logic [31:0]  hash_hi = '0;
   logic [31:0]  hash_nonce = '0;
   logic [3:0]   led;

   int checks = 0;
   int errors = 0;

   ltcminer_icarus_io #(
      .comm_clk_frequency(1_000_000),
      .baud_rate(115_200)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .RxD(RxD),
      .TxD(TxD),
      .work_data(work_data),
      .work_nonce(work_nonce),
      .work_load(work_load),
      .core_next(core_next),
      .hash_valid(hash_valid),
      .hash_hi(hash_hi),
      .hash_nonce(hash_nonce),
      .led(led)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- work_load pulse counter ----------------
   int load_cnt = 0;
   always @(posedge clk) if (work_load === 1'b1) load_cnt++;

   // ---------------- TxD monitor: 4 x 8N1 bytes per word ----------------
   logic [31:0] tx_q[$];
   int          tx_frame_err = 0;
   logic [31:0] mon_word;
   logic        mon_ok, mon_abort;
   int          mon_pos, mon_k, mon_b;

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && TxD === 1'b0) begin
            mon_word  = '0;
            mon_ok    = 1'b1;
            mon_abort = 1'b0;
            for (int i = 0; i < 40 * DIV; i++) begin
               if (i != 0) @(negedge clk);
               if (rst_n !== 1'b1) mon_abort = 1'b1;
               if (!mon_abort && (i % DIV) == DIV / 2) begin
                  mon_pos = i / DIV;
                  mon_k   = mon_pos / 10;
                  mon_b   = mon_pos % 10;
                  if (mon_b == 0) begin
                     if (TxD !== 1'b0) mon_ok = 1'b0;
                  end else if (mon_b == 9) begin
                     if (TxD !== 1'b1) mon_ok = 1'b0;
                  end else begin
                     mon_word[mon_k * 8 + mon_b - 1] = TxD;
                  end
               end
            end
            if (!mon_abort) begin
               tx_q.push_back(mon_word);
               if (!mon_ok) tx_frame_err++;
            end
         end
      end
   end

   // ---------------- checkers ----------------
   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check608(input string tag, input logic [607:0] obs, input logic [607:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   logic [7:0] fb [84];

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_frame(input logic [31:0] ctrl, input logic [31:0] start, input logic [7:0] seed);
      fb[0] = ctrl[31:24];  fb[1] = ctrl[23:16];  fb[2] = ctrl[15:8];  fb[3] = ctrl[7:0];
      fb[4] = start[31:24]; fb[5] = start[23:16]; fb[6] = start[15:8]; fb[7] = start[7:0];
      for (int i = 8; i < 84; i++) fb[i] = 8'(i * 37) ^ seed;
   endtask

   function automatic logic [607:0] exp_header();
      logic [607:0] h;
      h = '0;
      for (int i = 8; i < 84; i++) h = {h[599:0], fb[i]};
      return h;
   endfunction

   task automatic send_byte(input logic [7:0] b, input logic good_stop);
      RxD = 1'b0;
      wait_cycles(DIV);
      for (int j = 0; j < 8; j++) begin
         RxD = b[j];
         wait_cycles(DIV);
      end
      RxD = good_stop;
      wait_cycles(DIV);
      RxD = 1'b1;
   endtask

   // Sends the first n bytes of fb. The byte at bad_idx gets a low stop bit,
   // followed by two idle bit times so that the next start edge is clean.
   task automatic send_frame(input int n, input int bad_idx);
      for (int i = 0; i < n; i++) begin
         send_byte(fb[i], i != bad_idx);
         if (i == bad_idx) wait_cycles(2 * DIV);
      end
   endtask

   task automatic pulse_hash(input logic [31:0] hi, input logic [31:0] nonce);
      hash_valid = 1'b1;
      hash_hi    = hi;
      hash_nonce = nonce;
      wait_cycles(1);
      hash_valid = 1'b0;
   endtask

   task automatic pulse_next();
      core_next = 1'b1;
      wait_cycles(1);
      core_next = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   int          base;
   logic [31:0] w;
   logic [31:0] burst_hi [5];

   initial begin
      burst_hi[0] = 32'h0000_0000;
      burst_hi[1] = 32'h0000_0001;
      burst_hi[2] = 32'h0000_07ff;
      burst_hi[3] = 32'h0000_07fe;
      burst_hi[4] = 32'h0000_0000;

      // reset
      rst_n = 1'b0;
      wait_cycles(5);
      check32("reset_txd", 32'(TxD), 32'd1);
      check608("reset_work_data", work_data, '0);
      check32("reset_work_nonce", work_nonce, 32'h0);
      check32("reset_work_load", 32'(work_load), 32'd0);
      check32("reset_led", 32'(led), 32'h0);
      rst_n = 1'b1;
      wait_cycles(5);

      // frame 1: ctrl 55aa07ff, start 0000318e, header 7e71441b...
      set_frame(32'h55aa07ff, 32'h0000318e, 8'h00);
      fb[8] = 8'h7e; fb[9] = 8'h71; fb[10] = 8'h44; fb[11] = 8'h1b;
      base = load_cnt;
      send_frame(84, -1);
      wait_cycles(20);
      check32("f1_load_count", 32'(load_cnt - base), 32'd1);
      check32("f1_work_nonce", work_nonce, 32'h0000318e);
      check608("f1_work_data", work_data, exp_header());
      check32("f1_led_loaded", 32'(led[1]), 32'd1);

      // three core_next strobes
      for (int i = 0; i < 3; i++) pulse_next();
      wait_cycles(2);
      check32("next3_nonce", work_nonce, 32'h00003191);

      // hash exactly at target -> golden, sent 8f 31 00 00
      pulse_hash(32'h0000_07ff, 32'h0000_318f);
      wait_cycles(40 * DIV + 40);
      check32("gold_tx_count", 32'(tx_q.size()), 32'd1);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("gold_tx_word", w, 32'h0000_318f);
      check32("gold_led_seen", 32'(led[2]), 32'd1);
      check32("gold_tx_idle", 32'(led[3]), 32'd0);

      // hash one above target -> no transmission
      pulse_hash(32'h0000_0800, 32'h0000_0190);
      wait_cycles(50 * DIV);
      check32("above_target_tx", 32'(tx_q.size()), 32'd0);
      check32("above_target_txd", 32'(TxD), 32'd1);

      // one word in flight, then five matches back to back: the 5th is dropped
      pulse_hash(32'h0000_0000, 32'h1234_5678);
      wait_cycles(30);
      for (int k = 0; k < 5; k++) begin
         hash_valid = 1'b1;
         hash_hi    = burst_hi[k];
         hash_nonce = 32'ha000_0001 + 32'(k);
         wait_cycles(1);
      end
      hash_valid = 1'b0;
      wait_cycles(6 * 40 * DIV + 100);
      check32("burst_tx_count", 32'(tx_q.size()), 32'd5);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("burst_word0", w, 32'h1234_5678);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("burst_word1", w, 32'ha000_0001);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("burst_word2", w, 32'ha000_0002);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("burst_word3", w, 32'ha000_0003);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("burst_word4", w, 32'ha000_0004);
      check32("tx_framing_errors", 32'(tx_frame_err), 32'd0);
      tx_q.delete();

      // frame 2: start ffffffff wraps, new target 0010
      set_frame(32'h0000_0010, 32'hffff_ffff, 8'h5a);
      base = load_cnt;
      send_frame(84, -1);
      wait_cycles(20);
      check32("f2_load_count", 32'(load_cnt - base), 32'd1);
      check32("f2_work_nonce", work_nonce, 32'hffff_ffff);
      pulse_next();
      wait_cycles(2);
      check32("f2_nonce_wrap", work_nonce, 32'h0000_0000);
      pulse_hash(32'h0000_0011, 32'h0000_0001);
      pulse_hash(32'h0000_0010, 32'hbeef_0010);
      wait_cycles(40 * DIV + 60);
      check32("f2_target_count", 32'(tx_q.size()), 32'd1);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hxxxx_xxxx;
      check32("f2_target_word", w, 32'hbeef_0010);

      // 40 bytes, a stall longer than the timeout, then a full frame 3
      set_frame(32'h0000_0123, 32'h1111_2222, 8'hc3);
      base = load_cnt;
      send_frame(40, -1);
      wait_cycles(200);
      set_frame(32'h55aa_0200, 32'h3333_4444, 8'h77);
      send_frame(84, -1);
      wait_cycles(20);
      check32("f3_load_count", 32'(load_cnt - base), 32'd1);
      check32("f3_work_nonce", work_nonce, 32'h3333_4444);
      check608("f3_work_data", work_data, exp_header());

      // bad stop bit in byte 10: frame never completes; timeout clears it
      set_frame(32'h0000_0000, 32'h5555_6666, 8'h19);
      base = load_cnt;
      send_frame(84, 10);
      wait_cycles(300);
      check32("bad_stop_no_load", 32'(load_cnt - base), 32'd0);
      check32("bad_stop_nonce_kept", work_nonce, 32'h3333_4444);
      set_frame(32'h0000_0001, 32'h7777_8888, 8'h2e);
      base = load_cnt;
      send_frame(84, -1);
      wait_cycles(20);
      check32("f4_load_count", 32'(load_cnt - base), 32'd1);
      check32("f4_work_nonce", work_nonce, 32'h7777_8888);
      check608("f4_work_data", work_data, exp_header());

      // reset in the middle of a transmission
      pulse_hash(32'h0000_0000, 32'hdead_beef);
      wait_cycles(100);
      check32("pre_reset_tx_busy", 32'(led[3]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check32("reset_mid_tx_txd", 32'(TxD), 32'd1);
      check32("reset_mid_tx_led", 32'(led), 32'h0);
      check32("reset_mid_tx_nonce", work_nonce, 32'h0);
      check608("reset_mid_tx_data", work_data, '0);
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(50 * DIV);
      check32("post_reset_no_tx", 32'(tx_q.size()), 32'd0);
      check32("post_reset_txd", 32'(TxD), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
